// File: rtl/ram_read_streamer_if.sv
// Command, RAM read port and output stream of ram_read_streamer bundled as one interface.
// master is the streamer side; slave is the command source / RAM / consumer side.
interface ram_read_streamer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 15
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    output cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, ram_dout, out_ready,
    input  cmd_ready, ram_en, ram_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_read_streamer.sv
// Streams cmd_len+1 consecutive RAM words (wrapping at DEPTH) starting at cmd_addr,
// with a credit of two words covering the 1-cycle RAM latency plus a 2-entry output FIFO.
module ram_read_streamer #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 20480
) (
  input logic                 clock,
  input logic                 reset,
  ram_read_streamer_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, remaining, addr_hold;
  logic                  vld_p1, last_p1;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  rd_idx, wr_idx;
  logic [1:0]            count;
  logic                  accept, issue, push, pop, has_word, head_last;
  logic [1:0]            occ;

  assign has_word  = (count != 2'd0);
  assign push      = vld_p1;
  assign pop       = has_word & bus.out_ready;
  assign head_last = fifo_last[rd_idx];
  assign accept    = (state == IDLE) & bus.cmd_valid;
  // A word popped this cycle frees its credit immediately, keeping one read per cycle.
  assign occ       = ({1'b0, vld_p1} + count) - {1'b0, pop};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid) state_nxt = READ;
      READ:    if (issue && remaining == '0) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    issue         = 1'b0;
    case (state)
      IDLE:    bus.cmd_ready = 1'b1;
      READ:    issue = (occ < 2'd2);
      default: ;
    endcase
  end

  assign bus.ram_en   = issue;
  assign bus.ram_addr = issue ? ptr : addr_hold;

  // Issue stage -> p1: RAM data for a read issued now appears on ram_dout next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      remaining <= '0;
      addr_hold <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue && (remaining == '0);
      if (accept) begin
        ptr       <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (issue) begin
        ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + ONE;
        addr_hold <= ptr;
        if (remaining != '0) remaining <= remaining - ONE;
      end
    end
  end

  // p1 -> FIFO: capture is unconditional since credit reserved the slot at issue time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_idx    <= 1'b0;
      wr_idx    <= 1'b0;
      count     <= 2'd0;
      fifo_last <= 2'b00;
    end else begin
      if (push) begin
        fifo_last[wr_idx] <= last_p1;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_data[wr_idx] <= bus.ram_dout;
  end

  assign bus.out_valid = has_word;
  assign bus.out_data  = has_word ? fifo_data[rd_idx] : '0;
  assign bus.out_last  = has_word & head_last;

  always @(posedge clock) begin
    if (!reset) begin
      assert (!(push && count == 2'd2));
      assert (!(pop && count == 2'd0));
    end
  end
endmodule

// File: tb/tb_ram_read_streamer.sv
// Directed bench for ram_read_streamer: RAM model returns a known pattern per address,
// each command's issued addresses, output words, tags and timing are checked against it.
module tb_ram_read_streamer;
  localparam int DW    = 64;
  localparam int AW    = 15;
  localparam int DEPTH = 20480;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_read_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] word_of(input int a);
    return {32'hC0DE0000 + 32'(a), ~32'(a)};
  endfunction

  // One-cycle-latency RAM
  always @(posedge clock) begin
    if (bus.ram_en) bus.ram_dout <= word_of(int'(bus.ram_addr));
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int s_cyc;
  bit s_hs, s_ready, s_en;
  int iss_addr[$];
  int iss_cyc[$];
  logic [DW-1:0] out_d[$];
  logic out_l[$];
  int out_cyc[$];
  int first_valid;
  int issued = 0;
  int popped = 0;
  int max_occ;
  int prev_last = 0;

  task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Called at a negedge with inputs already set; samples mid-cycle, returns at next negedge.
  task automatic tick();
    #1;
    s_cyc   = cyc;
    s_hs    = bus.cmd_valid && bus.cmd_ready;
    s_ready = bus.cmd_ready;
    s_en    = bus.ram_en;
    if (bus.ram_en) begin
      iss_addr.push_back(int'(bus.ram_addr));
      iss_cyc.push_back(cyc);
      issued++;
    end
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    if (bus.out_valid && bus.out_ready) begin
      out_d.push_back(bus.out_data);
      out_l.push_back(bus.out_last);
      out_cyc.push_back(cyc);
      popped++;
    end
    if (issued - popped > max_occ) max_occ = issued - popped;
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    expect_eq({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
    expect_eq({pfx, "_ram_en"},    bus.ram_en,    0);
    expect_eq({pfx, "_ram_addr"},  bus.ram_addr,  0);
    expect_eq({pfx, "_out_valid"}, bus.out_valid, 0);
    expect_eq({pfx, "_out_last"},  bus.out_last,  0);
    expect_eq({pfx, "_out_data"},  bus.out_data,  0);
  endtask

  // mode 0: out_ready=1; mode 1: random out_ready with a 10-cycle stall at rel 4..13.
  task automatic run_cmd(input int addr, input int len, input int mode, input int abort_after,
                         input bit hold, input int next_addr, input int next_len, input bit chained);
    int n, acc, busy_rdy, stall_iss, rel, exp_a;
    n = len + 1; acc = -1; busy_rdy = 0; stall_iss = 0;
    iss_addr.delete(); iss_cyc.delete(); out_d.delete(); out_l.delete(); out_cyc.delete();
    first_valid = -1;
    max_occ = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    for (int k = 0; k < 20 && acc < 0; k++) begin
      bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (s_hs) acc = s_cyc;
    end
    expect_eq($sformatf("accept@%0d", addr), acc >= 0, 1);
    if (acc < 0) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    if (chained) expect_eq("holdoff_accept_cycle", acc, prev_last + 1);
    if (hold) begin
      bus.cmd_addr = AW'(next_addr);
      bus.cmd_len  = AW'(next_len);
    end else begin
      bus.cmd_valid = 1'b0;
    end

    while (out_d.size() < n && cyc - acc < 200) begin
      rel = cyc - acc;
      if (abort_after >= 0 && out_d.size() == abort_after) break;
      if (mode == 0)                   bus.out_ready = 1'b1;
      else if (rel >= 4 && rel < 14)   bus.out_ready = 1'b0;
      else                             bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (s_ready) busy_rdy++;
      if (mode != 0 && rel >= 6 && rel < 14 && s_en) stall_iss++;
    end

    if (abort_after >= 0) begin
      expect_eq("abort_point_words", out_d.size(), abort_after);
      bus.cmd_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clock);
      cyc++;
      reset = 1'b0;
      issued = 0;
      popped = 0;
      return;
    end

    expect_eq($sformatf("word_count@%0d", addr), out_d.size(), n);
    expect_eq($sformatf("issue_count@%0d", addr), iss_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      exp_a = (addr + i) % DEPTH;
      if (i < iss_addr.size())
        expect_eq($sformatf("ram_addr[%0d]@%0d", i, addr), iss_addr[i], exp_a);
      if (i < out_d.size()) begin
        expect_eq($sformatf("out_data[%0d]@%0d", i, addr), out_d[i], word_of(exp_a));
        expect_eq($sformatf("out_last[%0d]@%0d", i, addr), out_l[i], (i == len));
      end
    end
    expect_eq($sformatf("busy_cmd_ready@%0d", addr), busy_rdy, 0);
    expect_eq($sformatf("max_outstanding@%0d", addr), max_occ <= 2, 1);
    if (mode == 0 && out_d.size() == n && iss_addr.size() == n) begin
      // accept edge closes sample cycle acc; out_valid rises two edges later (sample acc+3)
      expect_eq($sformatf("first_valid_latency@%0d", addr), first_valid - acc, 3);
      expect_eq($sformatf("issue_span@%0d", addr), iss_cyc[n-1] - iss_cyc[0], n - 1);
      expect_eq($sformatf("out_span@%0d", addr), out_cyc[n-1] - out_cyc[0], n - 1);
    end
    if (mode != 0) expect_eq("stall_issues", stall_iss, 0);
    if (out_cyc.size() > 0) prev_last = out_cyc[out_cyc.size()-1];
    #1;
    expect_eq($sformatf("ready_after@%0d", addr), bus.cmd_ready, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    run_cmd(5,     0,  0, -1, 1'b0, 0,   0, 1'b0);
    run_cmd(100,   7,  0, -1, 1'b0, 0,   0, 1'b0);
    run_cmd(20478, 3,  0, -1, 1'b0, 0,   0, 1'b0);
    run_cmd(500,   15, 1, -1, 1'b0, 0,   0, 1'b0);
    run_cmd(40,    7,  0, 3,  1'b0, 0,   0, 1'b0);
    run_cmd(0,     1,  0, -1, 1'b0, 0,   0, 1'b0);
    run_cmd(200,   3,  0, -1, 1'b1, 300, 2, 1'b0);
    run_cmd(300,   2,  0, -1, 1'b0, 0,   0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ram_read_streamer.md
RAM_READ_STREAMER -- requirements
Module: ram_read_streamer

Interface
REQ-001 The block SHALL take parameters: DATA_WIDTH, default 512, word width of RAM read data and stream output.
REQ-002 The block SHALL take parameters: ADDR_WIDTH, default 15, RAM address width; DEPTH, default 20480, number of valid RAM words.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  read command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_addr  input  ADDR_WIDTH  first word address, 0..DEPTH-1.
- cmd_len  input  ADDR_WIDTH  number of words minus one.
- ram_en  output  1  RAM port enable, one read per cycle high.
- ram_addr  output  ADDR_WIDTH  RAM read address.
- ram_dout  input  DATA_WIDTH  RAM read data, valid exactly 1 cycle after the ram_en cycle.
- out_valid  output  1  stream word available.
- out_ready  input  1  consumer accepts word.
- out_data  output  DATA_WIDTH  stream word.
- out_last  output  1  marks final word of a command.

Function
REQ-004 The states SHALL be IDLE, READ and DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-005 cmd_valid&cmd_ready in IDLE SHALL latch the address pointer = cmd_addr and the remaining count = cmd_len, and SHALL go to READ.
REQ-006 In READ, a read SHALL be issued (ram_en=1, ram_addr=pointer) only when the in-flight reads plus the buffered words total less than 2.
REQ-007 On each issued read, the pointer SHALL increment and wrap from DEPTH-1 to 0; remaining SHALL decrement, and the read with remaining==0 SHALL be tagged last.
REQ-008 After the last read is issued, the state SHALL go to DRAIN; DRAIN SHALL return to IDLE in the cycle the last-tagged word is accepted on the output.
REQ-009 ram_dout SHALL be captured, together with its last tag, into a 2-entry FIFO in the cycle after its ram_en; capture SHALL be unconditional because credit guarantees space.
REQ-010 out_valid SHALL equal FIFO non-empty; out_data/out_last SHALL come from the FIFO head; a word SHALL be popped on out_valid&out_ready.
REQ-011 A simultaneous push and pop SHALL keep the occupancy unchanged; a push to a full FIFO or a pop from an empty FIFO SHALL never occur (assertion).
REQ-012 Credit SHALL count a popped word as freed in the same cycle, so that with out_ready held high, one read SHALL be issued per cycle.
REQ-013 Throughput with out_ready=1 SHALL be one word per cycle; command-to-first-out_valid latency SHALL be 2 cycles (accept, issue, capture).
REQ-014 ram_en SHALL be 0 in IDLE and DRAIN; ram_addr SHALL hold its last value when ram_en=0.
REQ-015 A cmd_addr >= DEPTH SHALL be treated as undefined input; the block SHALL still wrap from DEPTH-1 only.
REQ-016 A new command SHALL NOT be accepted until the previous command's last word has left the output.

Reset
REQ-017 On reset assertion, state SHALL be IDLE, with cmd_ready=1, ram_en=0, ram_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, pointer=0, remaining=0, in-flight=0.
REQ-018 Reset mid-command SHALL discard all buffered and in-flight words; data returned after reset SHALL be ignored.

Verification
REQ-019 Single word: cmd_addr=5, cmd_len=0, out_ready=1 -> one ram_en at addr 5; out_valid 2 cycles after accept with out_last=1; back to IDLE.
REQ-020 Streaming: cmd_addr=100, cmd_len=7, out_ready=1 -> ram_addr 100..107 on consecutive cycles; 8 back-to-back outputs; out_last on the 8th only.
REQ-021 Wrap: cmd_addr=20478, cmd_len=3 -> ram_addr 20478, 20479, 0, 1.
REQ-022 Backpressure: cmd_len=15, out_ready toggled randomly and held low for 10 cycles -> no more than 2 outstanding; no loss or duplication; ram_en stops while stalled; output order is preserved.
REQ-023 Reset mid-stream: assert reset after 3 of 8 words -> all outputs go to reset values immediately; a following command (addr 0, len 1) yields exactly 2 correct words.
REQ-024 Command hold-off: cmd_valid held high across a running command -> cmd_ready=0 until the cycle after the last word is popped; the next command starts cleanly.
